// File: rtl/tinyalu_pkg.sv
// ---------------------------------------------------------------------------
// tinyalu_pkg
// Shared types for the tinyalu command path:
//   operation_t  - tinyalu opcode encoding
//   cmd_t        - one queued command {A, B, op}
//   seq_state_t  - command sequencer FSM states
//   CMD_W        - flattened width of cmd_t, used on FIFO ports
//   TIMEOUT_RESULT - result word returned when the watchdog fires
// ---------------------------------------------------------------------------
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    // op is kept as raw bits so undefined encodings pass through to the ALU
    typedef struct packed {
        logic [7:0] A;
        logic [7:0] B;
        logic [2:0] op;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESP,
        GAP,
        RST
    } seq_state_t;

    localparam int          CMD_W          = $bits(cmd_t);
    localparam logic [15:0] TIMEOUT_RESULT = 16'hDEAD;

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// tinyalu_cmd_fifo
// DEPTH-entry show-ahead FIFO of tinyalu commands.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   push, push_data     write strobe and command (caller guarantees !full)
//   pop,  pop_data      read strobe and head command (valid when !empty)
//   full, empty, level  occupancy status
// Only the pointers and count are reset; storage is data and needs none.
// ---------------------------------------------------------------------------
module tinyalu_cmd_fifo
    import tinyalu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [CMD_W-1:0]         push_data,
    input  logic                     pop,
    output logic [CMD_W-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;

    assign full     = (count == LVL_W'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tinyalu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tinyalu_cmd_sequencer
// Buffers {A,B,op} commands from a valid/ready source, runs them one at a
// time through the tinyalu start/done handshake and returns each result on a
// valid/ready response port.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_a/b/op    command input (ready = FIFO not full)
//   rsp_valid/rsp_ready/rsp_result/rsp_op/rsp_err   response output
//   fifo_level                        current command FIFO occupancy
//   alu_A/alu_B/alu_op/alu_start/alu_reset_n        drive to tinyalu
//   alu_done/alu_result               from tinyalu
// Optional feature macro: TINYALU_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog
// that returns rsp_err=1 / 16'hDEAD after TIMEOUT_CYCLES without alu_done.
// ---------------------------------------------------------------------------
module tinyalu_cmd_sequencer
    import tinyalu_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    input  logic [2:0]               cmd_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [15:0]              rsp_result,
    output logic [2:0]               rsp_op,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               alu_A,
    output logic [7:0]               alu_B,
    output logic [2:0]               alu_op,
    output logic                     alu_start,
    output logic                     alu_reset_n,
    input  logic                     alu_done,
    input  logic [15:0]              alu_result
);

    seq_state_t       state_q, state_d;
    logic             rst_cnt_q;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CMD_W-1:0] head_bits;
    cmd_t             head_cmd;
    logic             load_hold, cap_rsp, tmo_hit, tmo_cap, rst_pulse;

    // Full blocks a new command even if IDLE pops in the same cycle
    assign cmd_ready   = !fifo_full;
    assign fifo_push   = cmd_valid && !fifo_full;
    assign head_cmd    = head_bits;
    assign alu_reset_n = reset_n && !rst_pulse;

    tinyalu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({cmd_a, cmd_b, cmd_op}),
        .pop       (fifo_pop),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

`ifdef TINYALU_SEQ_TIMEOUT_EN
    logic [15:0] wd_cnt_q;

    // Counter is held at zero outside WAIT_DONE, so it restarts on every entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
        end else if (state_q == WAIT_DONE) begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
        end else begin
            wd_cnt_q <= '0;
        end
    end

    assign tmo_hit = (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        load_hold = 1'b0;
        cap_rsp   = 1'b0;
        tmo_cap   = 1'b0;
        alu_start = 1'b0;
        rsp_valid = 1'b0;
        rst_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    load_hold = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                alu_start = 1'b1;
                if (alu_op == no_op)      state_d = GAP;
                else if (alu_op == rst_op) state_d = RST;
                else                       state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                alu_start = 1'b1;
                if (alu_done) begin
                    cap_rsp = 1'b1;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    tmo_cap = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            RST: begin
                rst_pulse = 1'b1;
                if (rst_cnt_q) state_d = GAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rst_cnt_q  <= 1'b0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_op     <= '0;
            rsp_result <= '0;
            rsp_op     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            // Second RST cycle is marked by rst_cnt_q=1
            rst_cnt_q <= (state_q == RST) && !rst_cnt_q;
            if (load_hold) begin
                alu_A  <= head_cmd.A;
                alu_B  <= head_cmd.B;
                alu_op <= head_cmd.op;
            end
            if (cap_rsp || tmo_cap) begin
                rsp_result <= tmo_cap ? TIMEOUT_RESULT : alu_result;
                rsp_op     <= alu_op;
                rsp_err    <= tmo_cap;
            end
        end
    end

endmodule
